// File: rtl/pipelined_add_sub_pkg.sv
// rtl/pipelined_add_sub_pkg.sv - shared parameter helpers for pipelined_add_sub
// Purpose: legality check and slice-width derivation for WIDTH/STAGES.
// Ports:   none (package).
package pipelined_add_sub_pkg;

   // WIDTH must split into STAGES equal, non-empty slices of at least one bit.
   function automatic bit params_legal(input int width, input int stages);
      return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

   // Bits handled by each pipeline slice.
   function automatic int chunk_width(input int width, input int stages);
      return (stages >= 1) ? (width / stages) : width;
   endfunction

endpackage

// File: rtl/pipelined_add_sub_if.sv
// rtl/pipelined_add_sub_if.sv - operand/result handshake bundle for pipelined_add_sub
// Purpose: groups the upstream operand channel and downstream result channel.
// Signals: in_valid/in_ready/a/b/cin/sub (operands), out_valid/out_ready/s/cout/ovf (result).
// Modports: slave = adder side, master = traffic source/sink side.
interface pipelined_add_sub_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, s, cout, ovf
   );

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, s, cout, ovf
   );
endinterface

// File: rtl/add_slice_st.sv
// rtl/add_slice_st.sv - structural W-bit ripple-carry slice
// Purpose: one pipeline slice of the carry chain built from full_adder_bh cells.
// Ports: a_i, b_i (W-bit operands), cin_i carry-in;
//        s_o W-bit sum, cout_o carry out of the slice MSB, cmsb_o carry into the slice MSB.
module add_slice_st #(
   parameter int W = 4
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W-1:0] s_o,
   output logic         cout_o,
   output logic         cmsb_o
);
   logic [W:0] c;

   assign c[0] = cin_i;

   for (genvar k = 0; k < W; k++) begin : g_bit
      full_adder_bh u_fa (
         .a_i  (a_i[k]),
         .b_i  (b_i[k]),
         .ci_i (c[k]),
         .s_o  (s_o[k]),
         .co_o (c[k+1])
      );
   end

   assign cout_o = c[W];
   assign cmsb_o = c[W-1];
endmodule

// File: rtl/full_adder_bh.sv
// rtl/full_adder_bh.sv - behavioural one-bit full adder cell
// Purpose: single carry-chain cell used by add_slice_st.
// Ports: a_i, b_i, ci_i (inputs); s_o sum, co_o carry-out.
module full_adder_bh (
   input  logic a_i,
   input  logic b_i,
   input  logic ci_i,
   output logic s_o,
   output logic co_o
);
   assign s_o  = a_i ^ b_i ^ ci_i;
   assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - pipelined WIDTH-bit adder/subtractor with valid/ready flow control
// Purpose: splits the carry chain into STAGES slices with a register after each slice,
//          giving one result per clock with back-pressure, borrow and signed overflow.
// Ports: clk, rst (async, active-high);
//        bus (pipelined_add_sub_if.slave): operands a/b/cin/sub with in_valid/in_ready,
//        results s/cout/ovf with out_valid/out_ready.
module pipelined_add_sub
   import pipelined_add_sub_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic               clk,
   input  logic               rst,
   pipelined_add_sub_if.slave bus
);
   localparam int CHUNK = chunk_width(WIDTH, STAGES);

   if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
      $error("pipelined_add_sub: WIDTH must be >= 2 and a multiple of STAGES, with 1 <= STAGES <= WIDTH");
   end

   // Per-stage state. opa/opb carry the operands still to be consumed (b already
   // conditionally inverted), sum holds the finished low bits, carry is the slice
   // carry-out, cmsb the carry into the slice MSB (meaningful at the last stage).
   logic [STAGES-1:0]            valid_q, valid_d;
   logic [STAGES-1:0][WIDTH-1:0] opa_q, opa_d;
   logic [STAGES-1:0][WIDTH-1:0] opb_q, opb_d;
   logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
   logic [STAGES-1:0]            carry_q, carry_d;
   logic [STAGES-1:0]            cmsb_q, cmsb_d;
   logic [STAGES-1:0]            sub_q, sub_d;

   // What each stage would load: the pipeline input for stage 0, the previous stage otherwise.
   logic [STAGES-1:0][WIDTH-1:0] src_a, src_b, src_s;
   logic [STAGES-1:0]            src_c, src_v, src_sub;

   logic [CHUNK-1:0] sl_a  [STAGES];
   logic [CHUNK-1:0] sl_b  [STAGES];
   logic [CHUNK-1:0] sl_s  [STAGES];
   logic             sl_co [STAGES];
   logic             sl_cm [STAGES];

   logic [STAGES-1:0] adv;

   always_comb begin
      src_a   = '0;
      src_b   = '0;
      src_s   = '0;
      src_c   = '0;
      src_v   = '0;
      src_sub = '0;
      // Subtraction runs as a + ~b + ~cin so the same carry chain yields a - b - cin.
      src_a[0]   = bus.a;
      src_b[0]   = bus.b ^ {WIDTH{bus.sub}};
      src_c[0]   = bus.cin ^ bus.sub;
      src_v[0]   = bus.in_valid;
      src_sub[0] = bus.sub;
      for (int i = 1; i < STAGES; i++) begin
         src_a[i]   = opa_q[i-1];
         src_b[i]   = opb_q[i-1];
         src_s[i]   = sum_q[i-1];
         src_c[i]   = carry_q[i-1];
         src_v[i]   = valid_q[i-1];
         src_sub[i] = sub_q[i-1];
      end
   end

   for (genvar i = 0; i < STAGES; i++) begin : g_slice
      assign sl_a[i] = src_a[i][i*CHUNK +: CHUNK];
      assign sl_b[i] = src_b[i][i*CHUNK +: CHUNK];

      add_slice_st #(.W(CHUNK)) u_slice (
         .a_i    (sl_a[i]),
         .b_i    (sl_b[i]),
         .cin_i  (src_c[i]),
         .s_o    (sl_s[i]),
         .cout_o (sl_co[i]),
         .cmsb_o (sl_cm[i])
      );
   end

   // A stage may take new contents when it is empty or its occupant moves on;
   // this collapses bubbles and lets a full pipeline accept while it drains.
   always_comb begin
      adv = '0;
      adv[STAGES-1] = bus.out_ready | ~valid_q[STAGES-1];
      for (int i = STAGES - 2; i >= 0; i--) begin
         adv[i] = adv[i+1] | ~valid_q[i];
      end
   end

   always_comb begin
      valid_d = valid_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cmsb_d  = cmsb_q;
      sub_d   = sub_q;
      for (int i = 0; i < STAGES; i++) begin
         if (adv[i]) begin
            valid_d[i] = src_v[i];
         end
         // Data only moves with a real transaction so held outputs stay put.
         if (adv[i] && src_v[i]) begin
            opa_d[i]                   = src_a[i];
            opb_d[i]                   = src_b[i];
            sum_d[i]                   = src_s[i];
            sum_d[i][i*CHUNK +: CHUNK] = sl_s[i];
            carry_d[i]                 = sl_co[i];
            cmsb_d[i]                  = sl_cm[i];
            sub_d[i]                   = src_sub[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         sum_q   <= '0;
         carry_q <= '0;
         cmsb_q  <= '0;
         sub_q   <= '0;
      end else begin
         valid_q <= valid_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cmsb_q  <= cmsb_d;
         sub_q   <= sub_d;
      end
   end

   assign bus.in_ready  = adv[0];
   assign bus.out_valid = valid_q[STAGES-1];
   assign bus.s         = sum_q[STAGES-1];
   // Raw carry out is inverted for subtraction so cout reads as borrow.
   assign bus.cout      = carry_q[STAGES-1] ^ sub_q[STAGES-1];
   assign bus.ovf       = cmsb_q[STAGES-1] ^ carry_q[STAGES-1];

   // Last-stage operand copies and non-final MSB carries have no reader.
   logic unused_tail;
   assign unused_tail = ^{opa_q[STAGES-1], opb_q[STAGES-1], cmsb_q};
endmodule
